// File: rtl/uart_tx_cfg.sv
// Queued UART transmitter: a character FIFO feeding a start/data/parity/stop
// shifter whose baud divisor, parity mode and stop-bit count are latched per frame.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic                        cfg_par_en,
  input  logic                        cfg_par_odd,
  input  logic                        cfg_stop2,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 4;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_DATA  = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Odd parity is the complement of the even-parity bit.
  function automatic logic parity_bit(input logic [DATA_W-1:0] ch, input logic odd);
    return (^ch) ^ odd;
  endfunction

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;

  state_e            state_q;
  logic              tx_q;
  logic              busy_q;
  logic [DIV_W-1:0]  timer_q;
  logic [DIV_W-1:0]  div_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;

  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              timer_zero_s;
  logic              last_stop_s;
  logic [DATA_W-1:0] rd_data_s;

  assign full_s       = (level_q == LEVEL_FULL);
  assign s_ready      = !full_s && !rst;
  assign push_s       = s_valid && s_ready;
  assign timer_zero_s = (timer_q == {DIV_W{1'b0}});
  assign last_stop_s  = (state_q == STOP) && timer_zero_s &&
                        (!stop2_q || (bit_cnt_q == 4'd1));
  assign pop_s        = (level_q != {LW{1'b0}}) && ((state_q == IDLE) || last_stop_s);
  assign rd_data_s    = mem_q[rd_ptr_q];

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

  // Queue occupancy after this cycle's push and/or pop.
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Frame sequencer; a pop at the end of the last stop bit chains straight into START.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      timer_q   <= {DIV_W{1'b0}};
      div_q     <= {DIV_W{1'b0}};
      bit_cnt_q <= {CW{1'b0}};
      shift_q   <= {DATA_W{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop_s) begin
      state_q   <= START;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
      timer_q   <= cfg_div;
      div_q     <= cfg_div;
      bit_cnt_q <= {CW{1'b0}};
      shift_q   <= rd_data_s;
      par_en_q  <= cfg_par_en;
      par_bit_q <= parity_bit(rd_data_s, cfg_par_odd);
      stop2_q   <= cfg_stop2;
    end else if (!timer_zero_s) begin
      timer_q <= timer_q - DIV_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        START: begin
          state_q   <= DATA;
          tx_q      <= shift_q[0];
          timer_q   <= div_q;
          bit_cnt_q <= {CW{1'b0}};
        end
        DATA: begin
          timer_q <= div_q;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_q <= {CW{1'b0}};
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
            shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
            tx_q      <= shift_q[1];
          end
        end
        PARITY: begin
          state_q   <= STOP;
          tx_q      <= 1'b1;
          timer_q   <= div_q;
          bit_cnt_q <= {CW{1'b0}};
        end
        STOP: begin
          if (stop2_q && (bit_cnt_q == 4'd0)) begin
            bit_cnt_q <= 4'd1;
            timer_q   <= div_q;
          end else begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected frames, a monitor
// samples tx/busy on every falling edge and compares whole frames.
module tb_uart_tx_cfg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [15:0] cfg_div;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_stop2;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          cpb;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  uart_tx_cfg #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .cfg_div     (cfg_div),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .tx          (tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Line levels in transmit order: start, data LSB first, optional parity, stop(s).
  function automatic exp_t mk(input logic [7:0] d, input bit pe, input bit pb,
                              input bit s2, input int cpb, input bit ab);
    exp_t        e;
    logic [15:0] v;
    logic [7:0]  t;
    int          n;
    v = 16'd0;
    t = d;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      v = v | (16'(t[0]) << n);
      t = t >> 1;
      n++;
    end
    if (pe) begin
      v = v | (16'(pb) << n);
      n++;
    end
    v = v | (16'd1 << n);
    n++;
    if (s2) begin
      v = v | (16'd1 << n);
      n++;
    end
    e.bits  = v;
    e.nbits = n;
    e.cpb   = cpb;
    e.abort = ab;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d, input exp_t e);
    step();
    s_valid = 1'b1;
    s_data  = d;
    exp_q.push_back(e);
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && fifo_level === 3'd0 && exp_q.size() == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk_eq("idle_reached", 32'(n < bound), 32'd1);
  endtask

  initial begin : monitor
    exp_t        it;
    logic [15:0] bv;
    int          bad;
    int          len;
    int          guard;
    bit          cont;
    bit          aborted;
    forever begin
      @(negedge clk);
      cont = (busy === 1'b1) && (rst === 1'b0);
      while (cont) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_frame", 32'(busy), 32'd0);
          guard = 0;
          while (busy === 1'b1 && rst === 1'b0 && guard < 20000) begin
            @(negedge clk);
            guard++;
          end
          cont = 1'b0;
        end else begin
          it      = exp_q.pop_front();
          len     = it.nbits * it.cpb;
          bad     = 0;
          aborted = 1'b0;
          for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            bv = it.bits >> (c / it.cpb);
            if (tx !== bv[0] || busy !== 1'b1) bad++;
          end
          chk_eq("frame_aborted", 32'(aborted), 32'(it.abort));
          chk_eq("frame_bits", 32'(bad), 32'd0);
          if (aborted) begin
            cont = 1'b0;
          end else begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
              chk_eq("b2b_start", {30'd0, busy, tx}, 32'd2);
            end else begin
              chk_eq("frame_end_idle", {30'd0, busy, tx}, 32'd1);
            end
            cont = (busy === 1'b1) && (rst === 1'b0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int acc;
    int busy_seen;
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = 8'h00;
    cfg_div     = 16'd3;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk_eq("rst_tx", 32'(tx), 32'd1);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_level", 32'(fifo_level), 32'd0);
    chk_eq("rst_ready", 32'(s_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_rst", 32'(s_ready), 32'd1);

    // Basic 8N1, 4 cycles per bit
    push1(8'hA5, mk(8'hA5, 1'b0, 1'b0, 1'b0, 4, 1'b0));
    @(negedge clk);
    chk_eq("t1_level_after_push", 32'(fifo_level), 32'd1);
    chk_eq("t1_idle_line", {30'd0, busy, tx}, 32'd1);
    step();
    @(negedge clk);
    chk_eq("t1_start_line", {30'd0, busy, tx}, 32'd2);
    chk_eq("t1_level_after_pop", 32'(fifo_level), 32'd0);
    wait_idle(200);

    // Parity: 0x07 has three ones
    cfg_par_en = 1'b1;
    push1(8'h07, mk(8'h07, 1'b1, 1'b1, 1'b0, 4, 1'b0));
    wait_idle(200);
    cfg_par_odd = 1'b1;
    push1(8'h07, mk(8'h07, 1'b1, 1'b0, 1'b0, 4, 1'b0));
    wait_idle(200);
    // 1 cycle/bit, odd parity, two stops: 12-cycle frame; 0x3A has four ones
    cfg_div   = 16'd0;
    cfg_stop2 = 1'b1;
    push1(8'h3A, mk(8'h3A, 1'b1, 1'b1, 1'b1, 1, 1'b0));
    wait_idle(100);
    cfg_div     = 16'd3;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;

    // Back-to-back frames
    step();
    s_valid = 1'b1;
    s_data  = 8'h55;
    exp_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 4, 1'b0));
    step();
    s_data = 8'h0F;
    exp_q.push_back(mk(8'h0F, 1'b0, 1'b0, 1'b0, 4, 1'b0));
    @(negedge clk);
    chk_eq("t3_level_0", 32'(fifo_level), 32'd1);
    step();
    s_data = 8'hF0;
    exp_q.push_back(mk(8'hF0, 1'b0, 1'b0, 1'b0, 4, 1'b0));
    @(negedge clk);
    chk_eq("t3_level_1", 32'(fifo_level), 32'd1);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk_eq("t3_level_2", 32'(fifo_level), 32'd2);
    repeat (38) step();
    @(negedge clk);
    chk_eq("t3_level_before_pop", 32'(fifo_level), 32'd2);
    step();
    @(negedge clk);
    chk_eq("t3_level_after_pop", 32'(fifo_level), 32'd1);
    wait_idle(300);

    // Full queue with a slow divisor
    cfg_div = 16'd100;
    acc     = 0;
    step();
    s_valid = 1'b1;
    s_data  = 8'h80;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        exp_q.push_back(mk(s_data, 1'b0, 1'b0, 1'b0, 101, 1'b0));
        acc++;
      end
      step();
      s_data = 8'h80 + 8'(acc);
    end
    @(negedge clk);
    chk_eq("t4_accepted", 32'(acc), 32'd5);
    chk_eq("t4_ready_full", 32'(s_ready), 32'd0);
    chk_eq("t4_level_full", 32'(fifo_level), 32'd4);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        exp_q.push_back(mk(s_data, 1'b0, 1'b0, 1'b0, 101, 1'b0));
        acc++;
      end
      step();
      s_data = 8'h80 + 8'(acc);
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk_eq("t4_accepted_refill", 32'(acc), 32'd6);
    chk_eq("t4_level_refill", 32'(fifo_level), 32'd4);
    wait_idle(8000);

    // Mid-frame configuration change; 0x5A has four ones
    cfg_div = 16'd3;
    step();
    s_valid = 1'b1;
    s_data  = 8'hC3;
    exp_q.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0, 4, 1'b0));
    step();
    s_data = 8'h5A;
    exp_q.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0, 8, 1'b0));
    step();
    s_valid = 1'b0;
    repeat (10) step();
    cfg_div    = 16'd7;
    cfg_par_en = 1'b1;
    wait_idle(400);
    cfg_div    = 16'd3;
    cfg_par_en = 1'b0;

    // Reset during data bit 3 with two characters queued
    step();
    s_valid = 1'b1;
    s_data  = 8'h96;
    exp_q.push_back(mk(8'h96, 1'b0, 1'b0, 1'b0, 4, 1'b1));
    step();
    s_data = 8'h11;
    step();
    s_data = 8'h22;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk_eq("t6_level_queued", 32'(fifo_level), 32'd2);
    repeat (16) step();
    rst = 1'b1;
    @(negedge clk);
    chk_eq("t6_ready_in_rst", 32'(s_ready), 32'd0);
    step();
    @(negedge clk);
    chk_eq("t6_rst_line", {30'd0, busy, tx}, 32'd1);
    chk_eq("t6_rst_level", 32'(fifo_level), 32'd0);
    step();
    rst       = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk_eq("t6_no_residual", 32'(busy_seen), 32'd0);
    push1(8'h3C, mk(8'h3C, 1'b0, 1'b0, 1'b0, 4, 1'b0));
    wait_idle(200);

    chk_eq("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
